// File: rtl/grf_writeback.sv
// 32 x 32-bit general register file with $0 hardwired to zero, optional write bypass and a write counter.
// Define GRF_TRACE_EN to print a golden-trace line on every effective write (simulation only).
module grf_writeback #(
    parameter int          BYPASS = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [4:0]       wa,
    input  logic [31:0]      wd,
    input  logic [31:0]      pc,
    input  logic [4:0]       ra1,
    input  logic [4:0]       ra2,
    output logic [31:0]      rd1,
    output logic [31:0]      rd2,
    output logic [CNT_W-1:0] wcnt
);

    logic [31:0] regs [0:31];
    logic        wr_eff;
    logic        byp1;
    logic        byp2;

    always_comb begin
        wr_eff = we && (wa != 5'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            wcnt <= '0;
        end else if (wr_eff) begin
            regs[wa] <= wd;
            wcnt     <= wcnt + CNT_W'(1);
        end
    end

    // Forwarding is suppressed while reset is held so every read returns zero.
    always_comb begin
        byp1 = (BYPASS != 0) && reset_n && wr_eff && (wa == ra1);
        byp2 = (BYPASS != 0) && reset_n && wr_eff && (wa == ra2);
        rd1  = '0;
        rd2  = '0;
        if (ra1 != 5'd0) begin
            rd1 = byp1 ? wd : regs[ra1];
        end
        if (ra2 != 5'd0) begin
            rd2 = byp2 ? wd : regs[ra2];
        end
    end

`ifdef GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset_n && wr_eff) begin
            $display("@%h: $%02d <= %h", pc, wa, wd);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_grf_writeback.sv
// Directed bench for grf_writeback: one bypassing 4-bit-counter instance and one
// non-bypassing 16-bit-counter instance share stimulus and are checked against a model.
module tb_grf_writeback;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        we      = 1'b0;
    logic [4:0]  wa      = '0;
    logic [31:0] wd      = '0;
    logic [31:0] pc      = '0;
    logic [4:0]  ra1     = '0;
    logic [4:0]  ra2     = '0;

    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic [3:0]  wcnt_b;
    logic [15:0] wcnt_n;

    int checks = 0;
    int errors = 0;

    logic [31:0] m [32];
    int unsigned cnt;
    logic [31:0] exp_q [$];
    string       names [6] = '{"rd1_byp", "rd2_byp", "rd1_nob", "rd2_nob", "wcnt_byp", "wcnt_nob"};

    grf_writeback #(.BYPASS(1), .CNT_W(4)) dut_byp (
        .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd), .pc(pc),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b), .wcnt(wcnt_b)
    );

    grf_writeback #(.BYPASS(0), .CNT_W(16)) dut_nob (
        .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd), .pc(pc),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n), .wcnt(wcnt_n)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mread(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'h0;
        if (!reset_n) return 32'h0;
        if (byp && we === 1'b1 && wa == a) return wd;
        return m[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        cnt = 0;
    endtask

    task automatic sample(input string tag);
        logic [31:0] obs [6];
        logic [31:0] e;
        exp_q.push_back(mread(ra1, 1'b1));
        exp_q.push_back(mread(ra2, 1'b1));
        exp_q.push_back(mread(ra1, 1'b0));
        exp_q.push_back(mread(ra2, 1'b0));
        exp_q.push_back(32'(cnt % 16));
        exp_q.push_back(32'(cnt % 65536));
        #1;
        obs[0] = rd1_b;
        obs[1] = rd2_b;
        obs[2] = rd1_n;
        obs[3] = rd2_n;
        obs[4] = {28'h0, wcnt_b};
        obs[5] = {16'h0, wcnt_n};
        for (int i = 0; i < 6; i++) begin
            e = exp_q.pop_front();
            checks++;
            assert (obs[i] === e) else begin
                errors++;
                $error("FAIL %s.%s observed=%h expected=%h", tag, names[i], obs[i], e);
            end
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        we = 1'b1; wa = a; wd = d; pc = p;
        @(posedge clk);
        if (reset_n && a != 5'd0) begin
            m[a] = d;
            cnt++;
        end
        #1;
        we = 1'b0;
    endtask

    task automatic idle();
        we = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        ra1 = 5'd5; ra2 = 5'd31;
        #2;
        sample("reset_held");
        reset_n = 1'b1;

        // Asynchronous reset between edges wipes a stored value at once.
        wr(5'd5, 32'h12345678, 32'h0);
        ra1 = 5'd5; ra2 = 5'd5;
        sample("w5");
        reset_n = 1'b0;
        model_reset();
        sample("async_rst");
        we = 1'b1; wa = 5'd5; wd = 32'hAAAA5555;
        sample("rst_no_bypass");
        we = 1'b0;
        reset_n = 1'b1;

        // Reset held across an edge dominates a write.
        idle();
        reset_n = 1'b0;
        we = 1'b1; wa = 5'd7; wd = 32'h77777777;
        @(posedge clk);
        #1;
        we = 1'b0;
        reset_n = 1'b1;
        ra1 = 5'd7; ra2 = 5'd0;
        sample("rst_dominates");

        wr(5'd8, 32'hDEADBEEF, 32'h00003000);
        ra1 = 5'd8; ra2 = 5'd8;
        sample("basic");

        wr(5'd0, 32'hFFFFFFFF, 32'h00003004);
        ra1 = 5'd0; ra2 = 5'd8;
        sample("zero_guard");

        wr(5'd9, 32'h00000001, 32'h00003008);
        we = 1'b1; wa = 5'd9; wd = 32'h00000002;
        ra1 = 5'd9; ra2 = 5'd8;
        sample("byp_pre");
        @(posedge clk);
        m[9] = 32'h2; cnt++;
        #1;
        we = 1'b0;
        sample("byp_post");

        we = 1'b1; wa = 5'd9; wd = 32'h00000003;
        ra1 = 5'd9; ra2 = 5'd9;
        sample("byp_both");
        @(posedge clk);
        m[9] = 32'h3; cnt++;
        #1;
        we = 1'b0;
        sample("byp_both_post");

        we = 1'b1; wa = 5'd0; wd = 32'h55555555;
        ra1 = 5'd0; ra2 = 5'd0;
        sample("byp_zero");
        idle();

        wr(5'd31, 32'h00003008, 32'h00003004);
        ra1 = 5'd31; ra2 = 5'd9;
        sample("jal");

        we = 1'b0; wa = 'x; wd = 'x;
        @(posedge clk);
        #1;
        wa = '0; wd = '0;
        ra1 = 5'd31; ra2 = 5'd9;
        sample("x_safe");

        reset_n = 1'b0;
        #1;
        model_reset();
        reset_n = 1'b1;
        ra1 = 5'd1; ra2 = 5'd0;
        for (int i = 1; i <= 17; i++) begin
            wr(5'd1, 32'(i) * 32'h01010101, 32'h00004000 + 32'(4 * i));
            idle();
            if (i == 15 || i == 16) sample($sformatf("wrap_%0d", i));
        end
        sample("wrap_17");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/grf_writeback.md
Name: grf_writeback

Overview:
- General register file of the single-cycle MIPS datapath.
- Sits directly downstream of the write-address select (rt / rd / $31) and the write-data select (ALU / memory / PC+4). Consumes their outputs.
- Supplies the rs/rt operands that feed the ALU B-source select and the jr target.
- Holds 32 x 32-bit registers with $0 hardwired to zero, an optional write-to-read bypass, and a retired-write counter.

Parameters:
- BYPASS, 1, 1 = a same-cycle write is forwarded onto a matching read port; 0 = reads return stored value only.
- CNT_W, 16, width of the retired-write counter wcnt.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- we  input  1  register write enable from control
- wa  input  5  write address (selected rt / rd / 31)
- wd  input  32  write data (selected ALU / Mem / PC+4)
- pc  input  32  PC of the instruction performing the write; trace only
- ra1  input  5  read address 1 (rs)
- ra2  input  5  read address 2 (rt)
- rd1  output  32  read data 1
- rd2  output  32  read data 2
- wcnt  output  CNT_W  count of effective writes since reset

Behaviour:
- Reset: reset_n low immediately clears all 32 registers and wcnt to 0, independent of clk.
  - rd1/rd2 read 0 for every address while reset is held.
  - Reset dominates any write in the same cycle.
- Release: the first write is taken at the first rising edge after reset_n is sampled high.
- Write: at rising edge, if we=1 and wa!=0, reg[wa] <= wd. Write is visible in stored state from the next cycle.
- $0: writes with wa=0 are discarded, reg[0] is never modified, and wcnt does not increment.
- Read: combinational, zero cycles latency.
  - rd1 = (ra1==0) ? 0 : reg[ra1]; same rule for rd2/ra2.
- Bypass (BYPASS=1): if we=1, wa!=0 and wa==ra1, rd1=wd in the same cycle. Same for port 2.
  - Both ports may bypass simultaneously when ra1==ra2==wa.
- Bypass (BYPASS=0): rd returns the pre-edge stored value.
- Counter: wcnt increments by 1 on every effective write (we=1, wa!=0).
  - Wraps modulo 2^CNT_W, all-ones to 0, with no saturation or flag.
- X-safety: we=0 with wa/wd unknown must not alter any state.
- There is no other state. Each cycle is independent beyond register contents and wcnt.

Optional Feature:
- Macro GRF_TRACE_EN.
- When defined: on every effective write, at the rising edge, print one simulation line "@<pc hex8>: $<wa dec2> <= <wd hex8>". This line format is the team's golden-trace format for comparison against the MARS reference.
  - No line is printed for wa=0 or for we=0.
  - Logic is simulation-only; synthesis netlist is identical with or without the macro.
- When undefined: no output, and the pc port is unused (left unconnected internally).

Test Plan:
- Reset: write 0x12345678 to $5, then pulse reset_n low mid-cycle (no clk edge) -> rd1(ra1=5)=0 immediately, wcnt=0.
- Basic write/read: we=1, wa=8, wd=0xDEADBEEF, edge; then ra1=8, ra2=8 -> rd1=rd2=0xDEADBEEF, wcnt=1.
- $0 guard: we=1, wa=0, wd=0xFFFFFFFF, edge; ra1=0 -> rd1=0, wcnt unchanged.
- Bypass: $9 holds 0x1, same cycle we=1, wa=9, wd=0x2, ra1=9 -> BYPASS=1 gives rd1=0x2 before edge; BYPASS=0 gives rd1=0x1 before edge, 0x2 after.
- jal-style write: we=1, wa=31, wd=0x00003008, pc=0x00003004 -> reg[31]=0x00003008. With GRF_TRACE_EN the printed line is "@00003004: $31 <= 00003008".
- Counter wrap: CNT_W=4, perform 17 writes to $1 -> wcnt=1; interleaved we=0 cycles leave wcnt unchanged.
